regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single regfile write port between NUM_REQ write-back sources
//  (0 = EXU, 1 = LSU, 2 = CSR).
//  Each cycle, a round-robin arbiter grants at most one valid request.
//  The granted write is registered and driven to the regfile write-back inputs with
//  1-cycle latency.
//  It also provides a stall input and a saturating contention counter for perf debug.
// PARAMETERS
//  NUM_REQ   3    number of write-back requesters (>=2)
//  CNT_W     32   width of contention counter
// PORTS
//  clk                  in   1           system clock, all state on posedge
//  rst                  in   1           synchronous, active-high reset
//  req_i_valid          in   NUM_REQ     request valid, one bit per source
//  req_i_rd             in   5*NUM_REQ   dest reg; source i at [5i+4:5i]
//  req_i_data           in   64*NUM_REQ  write data; source i at [64i+63:64i]
//  req_i_reg_wen        in   NUM_REQ     1 = real write, 0 = retire-only (consume, no write)
//  req_o_ready          out  NUM_REQ     one-hot grant; transfer = valid & ready
//  wb_i_stall           in   1           1 = grant nothing this cycle
//  write_back_o_rd      out  5           to regfile write_back_i_rd
//  write_back_o_data    out  64          to regfile write_back_i_data
//  write_back_o_reg_wen out  1           to regfile write_back_i_reg_wen
//  arb_o_conflict_cnt   out  CNT_W       cycles with >=2 valid requests, saturating
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - rr_ptr=0; write_back_o_rd=0, _data=0, _reg_wen=0; conflict_cnt=0.
//   - req_o_ready forced 0 while rst=1.
//  Grant (combinational from req_i_valid, rr_ptr, wb_i_stall, rst):
//   - Scan sources rr_ptr, rr_ptr+1, ... mod NUM_REQ; first valid wins.
//   - req_o_ready is one-hot or zero; never asserted for a non-valid source.
//   - wb_i_stall=1 or no valid request: req_o_ready=0.
//  Handshake:
//   - A source holds valid, rd, data and reg_wen stable until ready.
//   - Dropping valid before grant is illegal (no check required).
//   - The arbiter never back-pressures a granted transfer; 1 transfer/cycle max.
//  Pointer:
//   - On a transfer from source g: rr_ptr <= (g+1) mod NUM_REQ.
//   - No transfer: rr_ptr holds.
//   - Guarantees each continuously-valid source is served within NUM_REQ cycles.
//  Output stage (registered, latency 1):
//   - Transfer in cycle t: at t+1, write_back_o_rd/_data = granted payload.
//   - write_back_o_reg_wen = granted reg_wen AND (rd != 0).
//   - No transfer: write_back_o_reg_wen=0; rd/data hold previous values.
//  rd==0 / reg_wen==0:
//   - Request is still granted and consumed (ready=1); no regfile write issued.
//  Same rd from two sources in one cycle:
//   - Writes are serialised in grant order; the later write wins in the regfile.
//   - No merging.
//  Contention counter:
//   - +1 per cycle where popcount(req_i_valid) >= 2 and rst=0.
//   - Counted regardless of wb_i_stall.
//   - Saturates at all-ones; no wrap.
//  Reset mid-operation:
//   - Any transfer in the reset cycle is discarded; the next cycle outputs wen=0.
//   - Sources must re-present requests after reset.
// TESTING
//  1. Reset:
//     - Valid=3'b111 during rst -> ready=0, write_back_o_reg_wen=0, cnt=0, ptr=0.
//  2. Single source:
//     - LSU valid, rd=5, data=64'hDEAD_BEEF, wen=1 -> ready=3'b010 same cycle.
//     - Next cycle rd=5, data=DEAD_BEEF, reg_wen=1.
//  3. Round robin:
//     - All three valid for 6 cycles -> grants 0,1,2,0,1,2.
//     - conflict_cnt=6.
//  4. rd=0 / wen=0:
//     - EXU rd=0 wen=1 -> granted, output reg_wen=0.
//     - CSR rd=7 wen=0 -> granted, output reg_wen=0.
//  5. Stall:
//     - wb_i_stall=1 for 3 cycles with EXU+LSU valid -> ready=0, reg_wen=0, ptr unchanged.
//     - conflict_cnt +3; after release, EXU is granted first (ptr=0).
//  6. Saturation:
//     - CNT_W=4, 20 contention cycles -> cnt=4'hF, stays.
//     - Reset asserted mid-burst -> next-cycle outputs zero.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the single regfile write port between NUM_REQ
// write-back sources, with a registered write-back stage and a contention counter.
module regfile_wb_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_i_valid,
  input  logic [5*NUM_REQ-1:0]    req_i_rd,
  input  logic [64*NUM_REQ-1:0]   req_i_data,
  input  logic [NUM_REQ-1:0]      req_i_reg_wen,
  output logic [NUM_REQ-1:0]      req_o_ready,
  input  logic                    wb_i_stall,
  output logic [4:0]              write_back_o_rd,
  output logic [63:0]             write_back_o_data,
  output logic                    write_back_o_reg_wen,
  output logic [CNT_W-1:0]        arb_o_conflict_cnt
);

  localparam int unsigned RD_W   = 5;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned PTR_W  = $clog2(NUM_REQ);

  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  grant_idx;
  logic [PTR_W-1:0]  next_ptr;
  logic [PTR_W-1:0]  scan_idx;
  logic [PTR_W:0]    scan_sum;
  logic              xfer;
  logic [RD_W-1:0]   sel_rd;
  logic [DATA_W-1:0] sel_data;
  logic              sel_wen;
  logic              conflict_c;

  // Scan from rr_ptr upward (wrapping); the first valid source wins the port.
  always_comb begin : grant_scan
    req_o_ready = '0;
    grant_idx   = '0;
    xfer        = 1'b0;
    scan_sum    = '0;
    scan_idx    = '0;
    if (!rst && !wb_i_stall) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        scan_sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
        if (scan_sum >= (PTR_W+1)'(NUM_REQ)) begin
          scan_sum = scan_sum - (PTR_W+1)'(NUM_REQ);
        end
        scan_idx = scan_sum[PTR_W-1:0];
        if (!xfer && req_i_valid[scan_idx]) begin
          xfer                  = 1'b1;
          grant_idx             = scan_idx;
          req_o_ready[scan_idx] = 1'b1;
        end
      end
    end
  end

  // One-hot payload select of the granted source.
  always_comb begin : payload_mux
    sel_rd   = '0;
    sel_data = '0;
    sel_wen  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_o_ready[i]) begin
        sel_rd   = sel_rd   | req_i_rd[RD_W*i +: RD_W];
        sel_data = sel_data | req_i_data[DATA_W*i +: DATA_W];
        sel_wen  = sel_wen  | req_i_reg_wen[i];
      end
    end
  end

  always_comb begin : ptr_next
    next_ptr = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
  end

  assign conflict_c = ($countones(req_i_valid) >= 2);

  // Pointer, write-back stage and saturating contention counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr               <= '0;
      write_back_o_rd      <= '0;
      write_back_o_data    <= '0;
      write_back_o_reg_wen <= 1'b0;
      arb_o_conflict_cnt   <= '0;
    end else begin
      if (xfer) begin
        rr_ptr               <= next_ptr;
        write_back_o_rd      <= sel_rd;
        write_back_o_data    <= sel_data;
        write_back_o_reg_wen <= sel_wen && (sel_rd != '0);
      end else begin
        write_back_o_reg_wen <= 1'b0;
      end
      if (conflict_c && (arb_o_conflict_cnt != {CNT_W{1'b1}})) begin
        arb_o_conflict_cnt <= arb_o_conflict_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus random
// traffic compared against a behavioural round-robin model.
module tb_regfile_wb_arbiter;

  localparam int unsigned N = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [5*N-1:0]  req_rd;
  logic [64*N-1:0] req_data;
  logic [N-1:0]  req_wen;
  logic          stall;

  logic [N-1:0]  ready, ready4;
  logic [4:0]    wb_rd, wb_rd4;
  logic [63:0]   wb_data, wb_data4;
  logic          wb_wen, wb_wen4;
  logic [31:0]   cnt;
  logic [3:0]    cnt4;

  regfile_wb_arbiter #(.NUM_REQ(N), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .req_i_valid(req_valid), .req_i_rd(req_rd),
    .req_i_data(req_data), .req_i_reg_wen(req_wen), .req_o_ready(ready),
    .wb_i_stall(stall), .write_back_o_rd(wb_rd), .write_back_o_data(wb_data),
    .write_back_o_reg_wen(wb_wen), .arb_o_conflict_cnt(cnt)
  );

  regfile_wb_arbiter #(.NUM_REQ(N), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .req_i_valid(req_valid), .req_i_rd(req_rd),
    .req_i_data(req_data), .req_i_reg_wen(req_wen), .req_o_ready(ready4),
    .wb_i_stall(stall), .write_back_o_rd(wb_rd4), .write_back_o_data(wb_data4),
    .write_back_o_reg_wen(wb_wen4), .arb_o_conflict_cnt(cnt4)
  );

  always #5 clk = ~clk;

  // Source-side request state
  bit          sv[N];
  logic [4:0]  srd[N];
  logic [63:0] sdata[N];
  bit          swen[N];

  // Reference model state
  int          m_ptr;
  logic [4:0]  m_rd;
  logic [63:0] m_data;
  bit          m_wen;
  longint      m_cnt;
  longint      m_cnt4;

  logic [N-1:0] obs_ready;
  int tests = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_src(input int i, input bit v, input logic [4:0] rd,
                         input logic [63:0] data, input bit wen);
    sv[i] = v; srd[i] = rd; sdata[i] = data; swen[i] = wen;
  endtask

  task automatic clear_srcs();
    for (int i = 0; i < N; i++) set_src(i, 1'b0, 5'd0, 64'd0, 1'b0);
  endtask

  // First valid source at or after the pointer, modulo N.
  function automatic int model_winner();
    if (rst || stall) return -1;
    for (int k = 0; k < N; k++) begin
      if (sv[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  // One clock: drive, check grant, advance model, check registered outputs.
  task automatic step();
    int w;
    int nvalid;
    logic [N-1:0] exp_ready;
    for (int i = 0; i < N; i++) begin
      req_valid[i]         = sv[i];
      req_rd[5*i +: 5]     = srd[i];
      req_data[64*i +: 64] = sdata[i];
      req_wen[i]           = swen[i];
    end
    #1;
    w = model_winner();
    exp_ready = (w < 0) ? '0 : N'(1 << w);
    obs_ready = ready;
    check("ready", 64'(ready), 64'(exp_ready));
    check("ready_sat", 64'(ready4), 64'(exp_ready));
    nvalid = 0;
    for (int i = 0; i < N; i++) nvalid += int'(sv[i]);
    @(posedge clk);
    if (rst) begin
      m_ptr = 0; m_rd = '0; m_data = '0; m_wen = 1'b0; m_cnt = 0; m_cnt4 = 0;
    end else begin
      if (w >= 0) begin
        m_ptr  = (w + 1) % N;
        m_rd   = srd[w];
        m_data = sdata[w];
        m_wen  = swen[w] && (srd[w] != 5'd0);
        sv[w]  = 1'b0;
      end else begin
        m_wen = 1'b0;
      end
      if (nvalid >= 2) begin
        if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
      end
    end
    #1;
    check("wb_rd", 64'(wb_rd), 64'(m_rd));
    check("wb_data", wb_data, m_data);
    check("wb_wen", 64'(wb_wen), 64'(m_wen));
    check("wb_wen_sat", 64'(wb_wen4), 64'(m_wen));
    check("conflict_cnt", 64'(cnt), 64'(m_cnt));
    check("conflict_cnt_sat", 64'(cnt4), 64'(m_cnt4));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0;
    req_valid = '0; req_rd = '0; req_data = '0; req_wen = '0;
    m_ptr = 0; m_rd = '0; m_data = '0; m_wen = 1'b0; m_cnt = 0; m_cnt4 = 0;
    clear_srcs();

    // Reset with all sources requesting
    for (int i = 0; i < N; i++) set_src(i, 1'b1, 5'(i + 1), 64'(i), 1'b1);
    step();
    check("rst_ready", 64'(obs_ready), 64'd0);
    check("rst_wen", 64'(wb_wen), 64'd0);
    check("rst_cnt", 64'(cnt), 64'd0);
    clear_srcs();
    do_reset();

    // Single LSU request
    set_src(1, 1'b1, 5'd5, 64'hDEAD_BEEF, 1'b1);
    step();
    check("lsu_ready", 64'(obs_ready), 64'b010);
    check("lsu_rd", 64'(wb_rd), 64'd5);
    check("lsu_data", wb_data, 64'hDEAD_BEEF);
    check("lsu_wen", 64'(wb_wen), 64'd1);

    // Round robin with all three continuously valid
    do_reset();
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N; i++) set_src(i, 1'b1, 5'(8 + 4 * k + i), {32'(k), 32'(i)}, 1'b1);
      step();
      check("rr_order", 64'(obs_ready), 64'(1 << (k % 3)));
    end
    check("rr_cnt", 64'(cnt), 64'd6);
    clear_srcs();

    // rd==0 and wen==0 are consumed without a write
    do_reset();
    set_src(0, 1'b1, 5'd0, 64'h1234, 1'b1);
    step();
    check("rd0_ready", 64'(obs_ready), 64'b001);
    check("rd0_wen", 64'(wb_wen), 64'd0);
    set_src(2, 1'b1, 5'd7, 64'h5678, 1'b0);
    step();
    check("nowen_ready", 64'(obs_ready), 64'b100);
    check("nowen_wen", 64'(wb_wen), 64'd0);
    check("nowen_rd", 64'(wb_rd), 64'd7);

    // Stall blocks grants but contention still counts
    do_reset();
    set_src(0, 1'b1, 5'd3, 64'hA, 1'b1);
    set_src(1, 1'b1, 5'd4, 64'hB, 1'b1);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_ready", 64'(obs_ready), 64'd0);
    end
    check("stall_cnt", 64'(cnt), 64'd3);
    stall = 1'b0;
    step();
    check("post_stall_ready", 64'(obs_ready), 64'b001);

    // Saturation of the narrow counter, then reset mid-burst
    do_reset();
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < N; i++) set_src(i, 1'b1, 5'(1 + i), 64'(k * 3 + i), 1'b1);
      step();
    end
    check("sat_cnt", 64'(cnt4), 64'hF);
    check("wide_cnt", 64'(cnt), 64'd20);
    for (int i = 0; i < N; i++) set_src(i, 1'b1, 5'(1 + i), 64'hFF, 1'b1);
    rst = 1'b1;
    step();
    check("midrst_wen", 64'(wb_wen), 64'd0);
    check("midrst_cnt", 64'(cnt4), 64'd0);
    rst = 1'b0;
    clear_srcs();

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!sv[i] && ($urandom_range(0, 9) < 4)) begin
          set_src(i, 1'b1,
                  ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                  {32'($urandom), 32'($urandom)}, 1'($urandom_range(0, 1)));
        end
      end
      stall = ($urandom_range(0, 4) == 0);
      rst   = ($urandom_range(0, 60) == 0);
      step();
    end
    rst = 1'b0; stall = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
